latch_writer: RTL and testbench

- Write-side controller for the n-bit transparent latch used across the russian/ datapath.
- Accepts a word from an upstream ready/valid source and drives the latch data bus with timed setup, strobe and hold phases, so the latch captures a stable value.
- Also owns the latch output-enable (active-low) and arbitrates read requests against write transactions.
- Sits between the sequencer/register-file logic and each latch instance; one writer per latch.

---
 rtl/russian_pkg.sv | 36 +++
 rtl/phase_counter.sv | 36 +++
 rtl/latch_writer.sv | 161 ++++++++++++++++
 tb/tb_latch_writer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/russian_pkg.sv
// Shared definitions for the russian/ latch datapath.
//
// Contents:
//   writer_state_t  - state encoding for latch write controllers
//   DEFAULT_*       - default word width and phase lengths, in clock cycles
//   phase_width()   - width of a phase counter that must hold every phase length
package russian_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } writer_state_t;

    localparam int DEFAULT_LENGTH        = 8;
    localparam int DEFAULT_SETUP_CYCLES  = 1;
    localparam int DEFAULT_STROBE_CYCLES = 2;
    localparam int DEFAULT_HOLD_CYCLES   = 1;

    // clog2(max(setup, strobe, hold) + 1), never narrower than one bit.
    function automatic int phase_width(input int setup, input int strobe, input int hold);
        int longest;
        int w;
        longest = setup;
        if (strobe > longest) longest = strobe;
        if (hold > longest) longest = hold;
        w = 0;
        while ((1 << w) < (longest + 1)) begin
            w = w + 1;
        end
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Down-counter used to time the phases of a latch strobe sequence.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset, clears the count
//   load       - load load_value this cycle (takes priority over decrement)
//   load_value - value loaded at phase entry (phase length minus one)
//   decrement  - count down by one; the count holds at zero and never wraps
//   zero       - count is zero, i.e. the current phase ends this cycle
module phase_counter #(
    parameter int width = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [width-1:0] load_value,
    input  logic             decrement,
    output logic             zero
);

    logic [width-1:0] count;

    // Reload on phase entry, otherwise count down and stick at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && (count != '0)) begin
            count <= count - width'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/latch_writer.sv
// Write-side controller for one n-bit transparent latch.
//
// A word accepted from a ready/valid source is driven onto the latch data bus,
// held for setup_cycles, strobed with latch_enable for strobe_cycles, then held
// for hold_cycles. The latch output enable is only granted while the writer is
// idle and not accepting a word, so the latch never drives while being written.
//
// Ports:
//   clk           - system clock, rising edge
//   reset_n       - asynchronous active-low reset
//   in_data       - word to be written
//   in_valid      - upstream word valid
//   in_ready      - writer accepts a word this cycle
//   read_req      - request to enable the latch outputs
//   data          - latch data input
//   latch_enable  - latch enable, high = transparent
//   outputenablen - latch output enable, active low
//   busy          - write transaction in progress
//   done          - one-cycle pulse in the cycle the writer returns to idle
//
// Every output is a flop; next values are computed from the next state so the
// outputs line up with the state they describe.
module latch_writer
    import russian_pkg::*;
#(
    parameter int length        = DEFAULT_LENGTH,
    parameter int setup_cycles  = DEFAULT_SETUP_CYCLES,
    parameter int strobe_cycles = DEFAULT_STROBE_CYCLES,
    parameter int hold_cycles   = DEFAULT_HOLD_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [length-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              read_req,
    output logic [length-1:0] data,
    output logic              latch_enable,
    output logic              outputenablen,
    output logic              busy,
    output logic              done
);

    localparam int CW = phase_width(setup_cycles, strobe_cycles, hold_cycles);

    // The counter is loaded with length-1 so that a phase ends when it reads zero.
    localparam logic [CW-1:0] SETUP_LOAD  = CW'((setup_cycles  > 0) ? setup_cycles  - 1 : 0);
    localparam logic [CW-1:0] STROBE_LOAD = CW'((strobe_cycles > 0) ? strobe_cycles - 1 : 0);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'((hold_cycles   > 0) ? hold_cycles   - 1 : 0);

    // Reject parameter sets that cannot produce a valid strobe.
    if (strobe_cycles < 1) begin : g_bad_strobe
        $error("latch_writer: strobe_cycles must be at least 1");
    end
    if ((setup_cycles < 0) || (hold_cycles < 0)) begin : g_bad_phase
        $error("latch_writer: setup_cycles and hold_cycles must not be negative");
    end

    writer_state_t state;
    writer_state_t state_next;
    logic          accept;
    logic          load;
    logic [CW-1:0] load_value;
    logic          decrement;
    logic          phase_zero;

    phase_counter #(
        .width(CW)
    ) u_phase_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_value(load_value),
        .decrement (decrement),
        .zero      (phase_zero)
    );

    // A word is taken only in IDLE with in_ready already up; in_ready is held
    // low for the first cycle after reset so nothing is accepted then.
    assign accept = (state == IDLE) && in_valid && in_ready;

    // Next-state logic. Each phase entry reloads the counter; zero-length
    // setup and hold phases are skipped entirely.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_value = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    if (setup_cycles > 0) begin
                        state_next = SETUP;
                        load_value = SETUP_LOAD;
                    end else begin
                        state_next = STROBE;
                        load_value = STROBE_LOAD;
                    end
                end
            end
            SETUP: begin
                if (phase_zero) begin
                    state_next = STROBE;
                    load       = 1'b1;
                    load_value = STROBE_LOAD;
                end
            end
            STROBE: begin
                if (phase_zero) begin
                    if (hold_cycles > 0) begin
                        state_next = HOLD;
                        load       = 1'b1;
                        load_value = HOLD_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            HOLD: begin
                if (phase_zero) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign decrement = (state != IDLE) && !load && !phase_zero;

    // State and registered outputs. Reset drops latch_enable immediately and
    // abandons any word in flight without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            data          <= '0;
            latch_enable  <= 1'b0;
            outputenablen <= 1'b1;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state        <= state_next;
            if (accept) begin
                data <= in_data;
            end
            latch_enable <= (state_next == STROBE);
            in_ready     <= (state_next == IDLE);
            busy         <= (state_next != IDLE);
            done         <= (state != IDLE) && (state_next == IDLE);
            // A write always wins over a read request in the same cycle.
            if ((state == IDLE) && !accept) begin
                outputenablen <= ~read_req;
            end else begin
                outputenablen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_latch_writer.sv
// Directed self-checking bench for latch_writer.
//
// dut_a uses the default phases (setup 1, strobe 2, hold 1); dut_b uses
// setup 0, strobe 1, hold 0 for back-to-back streaming. Each DUT feeds a
// behavioural transparent latch so the value actually captured can be checked.
module tb_latch_writer;

    logic       clk;
    logic       reset_n;

    logic [7:0] in_data_a,  in_data_b;
    logic       in_valid_a, in_valid_b;
    logic       in_ready_a, in_ready_b;
    logic       read_req_a, read_req_b;
    logic [7:0] data_a,     data_b;
    logic       le_a,       le_b;
    logic       oe_n_a,     oe_n_b;
    logic       busy_a,     busy_b;
    logic       done_a,     done_b;

    logic [7:0] latch_q_a = 8'h00;
    logic [7:0] latch_q_b = 8'h00;
    int         strobes_a = 0;
    int         strobes_b = 0;

    int checks = 0;
    int errors = 0;
    int snap;

    latch_writer dut_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_data      (in_data_a),
        .in_valid     (in_valid_a),
        .in_ready     (in_ready_a),
        .read_req     (read_req_a),
        .data         (data_a),
        .latch_enable (le_a),
        .outputenablen(oe_n_a),
        .busy         (busy_a),
        .done         (done_a)
    );

    latch_writer #(
        .length       (8),
        .setup_cycles (0),
        .strobe_cycles(1),
        .hold_cycles  (0)
    ) dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_data      (in_data_b),
        .in_valid     (in_valid_b),
        .in_ready     (in_ready_b),
        .read_req     (read_req_b),
        .data         (data_b),
        .latch_enable (le_b),
        .outputenablen(oe_n_b),
        .busy         (busy_b),
        .done         (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural transparent latches and strobe counters.
    always_latch begin
        if (le_a) latch_q_a <= data_a;
    end
    always_latch begin
        if (le_b) latch_q_b <= data_b;
    end
    always @(posedge le_a) strobes_a <= strobes_a + 1;
    always @(posedge le_b) strobes_b <= strobes_b + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit sel, input logic valid, input logic [7:0] word,
                                 input logic read);
        if (sel == 1'b0) begin
            in_valid_a = valid;
            in_data_a  = word;
            read_req_a = read;
        end else begin
            in_valid_b = valid;
            in_data_b  = word;
            read_req_b = read;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        reset_n = 1'b0;
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1, 1'b0, 8'h00, 1'b0);

        // Reset state
        tick();
        tick();
        checkOutput("rst data_a",     data_a,     0);
        checkOutput("rst le_a",       le_a,       0);
        checkOutput("rst oe_n_a",     oe_n_a,     1);
        checkOutput("rst in_ready_a", in_ready_a, 0);
        checkOutput("rst busy_a",     busy_a,     0);
        checkOutput("rst done_a",     done_a,     0);
        reset_n = 1'b1;
        #1;
        checkOutput("rel in_ready_a before edge", in_ready_a, 0);
        tick();
        checkOutput("rel in_ready_a", in_ready_a, 1);
        checkOutput("rel in_ready_b", in_ready_b, 1);
        checkOutput("rel busy_a",     busy_a,     0);
        checkOutput("rel oe_n_a",     oe_n_a,     1);
        checkOutput("rel data_a",     data_a,     0);

        // Single write, default phases
        $display("[TB] single write");
        snap = strobes_a;
        applyStimulus(0, 1'b1, 8'hA5, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        checkOutput("sw e1 data",     data_a,     8'hA5);
        checkOutput("sw e1 busy",     busy_a,     1);
        checkOutput("sw e1 in_ready", in_ready_a, 0);
        checkOutput("sw e1 le",       le_a,       0);
        tick();
        checkOutput("sw e2 le",       le_a,       1);
        tick();
        checkOutput("sw e3 le",       le_a,       1);
        checkOutput("sw e3 done",     done_a,     0);
        tick();
        checkOutput("sw e4 le",       le_a,       0);
        checkOutput("sw e4 busy",     busy_a,     1);
        checkOutput("sw e4 done",     done_a,     0);
        tick();
        checkOutput("sw e5 done",     done_a,     1);
        checkOutput("sw e5 in_ready", in_ready_a, 1);
        checkOutput("sw e5 busy",     busy_a,     0);
        tick();
        checkOutput("sw e6 done",     done_a,     0);
        checkOutput("sw e6 data",     data_a,     8'hA5);
        checkOutput("sw latch",       latch_q_a,  8'hA5);
        checkOutput("sw strobes",     strobes_a - snap, 1);

        // Back-to-back stream on the 0/1/0 writer
        $display("[TB] back-to-back");
        snap = strobes_b;
        applyStimulus(1, 1'b1, 8'h01, 1'b0);
        tick();
        applyStimulus(1, 1'b1, 8'h02, 1'b0);
        checkOutput("bb e1 le",       le_b,       1);
        checkOutput("bb e1 data",     data_b,     8'h01);
        checkOutput("bb e1 in_ready", in_ready_b, 0);
        tick();
        checkOutput("bb e2 le",       le_b,       0);
        checkOutput("bb e2 done",     done_b,     1);
        checkOutput("bb e2 in_ready", in_ready_b, 1);
        checkOutput("bb e2 data",     data_b,     8'h01);
        tick();
        checkOutput("bb e3 le",       le_b,       1);
        checkOutput("bb e3 data",     data_b,     8'h02);
        checkOutput("bb e3 done",     done_b,     0);
        applyStimulus(1, 1'b1, 8'h03, 1'b0);
        tick();
        checkOutput("bb e4 done",     done_b,     1);
        tick();
        applyStimulus(1, 1'b0, 8'h00, 1'b0);
        checkOutput("bb e5 le",       le_b,       1);
        checkOutput("bb e5 data",     data_b,     8'h03);
        tick();
        checkOutput("bb e6 done",     done_b,     1);
        checkOutput("bb e6 le",       le_b,       0);
        tick();
        checkOutput("bb e7 busy",     busy_b,     0);
        checkOutput("bb e7 done",     done_b,     0);
        checkOutput("bb e7 in_ready", in_ready_b, 1);
        checkOutput("bb strobes",     strobes_b - snap, 3);
        checkOutput("bb latch",       latch_q_b,  8'h03);

        // Read arbitration
        $display("[TB] read arbitration");
        applyStimulus(0, 1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("rd idle oe_n",   oe_n_a,     0);
        applyStimulus(0, 1'b1, 8'h3C, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 8'h3C, 1'b1);
        checkOutput("ra e1 oe_n",     oe_n_a,     1);
        checkOutput("ra e1 data",     data_a,     8'h3C);
        checkOutput("ra e1 busy",     busy_a,     1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("ra e%0d oe_n", i), oe_n_a, 1);
        end
        tick();
        checkOutput("ra e5 done",     done_a,     1);
        checkOutput("ra e5 oe_n",     oe_n_a,     1);
        tick();
        checkOutput("ra e6 oe_n",     oe_n_a,     0);
        checkOutput("ra e6 done",     done_a,     0);
        checkOutput("ra latch",       latch_q_a,  8'h3C);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("ra e7 oe_n",     oe_n_a,     1);

        // Upstream holds in_valid through a busy transaction
        $display("[TB] upstream stall");
        snap = strobes_a;
        applyStimulus(0, 1'b1, 8'hFF, 1'b0);
        tick();
        checkOutput("st e1 data",     data_a,     8'hFF);
        checkOutput("st e1 in_ready", in_ready_a, 0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("st e%0d in_ready", i), in_ready_a, 0);
            checkOutput($sformatf("st e%0d busy", i),     busy_a,     1);
            checkOutput($sformatf("st e%0d done", i),     done_a,     0);
        end
        tick();
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        checkOutput("st e5 done",     done_a,     1);
        checkOutput("st e5 in_ready", in_ready_a, 1);
        tick();
        checkOutput("st e6 busy",     busy_a,     0);
        checkOutput("st e6 done",     done_a,     0);
        checkOutput("st strobes",     strobes_a - snap, 1);
        checkOutput("st latch",       latch_q_a,  8'hFF);

        // Reset in the middle of the strobe
        $display("[TB] mid-strobe reset");
        applyStimulus(0, 1'b1, 8'h5A, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("mr le before",   le_a,       1);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("mr le async",    le_a,       0);
        checkOutput("mr data async",  data_a,     0);
        checkOutput("mr busy async",  busy_a,     0);
        checkOutput("mr in_ready",    in_ready_a, 0);
        checkOutput("mr done async",  done_a,     0);
        tick();
        checkOutput("mr done held",   done_a,     0);
        reset_n = 1'b1;
        tick();
        checkOutput("mr rel in_ready", in_ready_a, 1);
        checkOutput("mr rel data",     data_a,     0);
        checkOutput("mr rel done",     done_a,     0);
        tick();
        checkOutput("mr rel2 done",    done_a,     0);
        checkOutput("mr rel2 le",      le_a,       0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
